// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, fixed 10-cycle turnaround).
// Optional macro BCD2BIN_DIGIT_CHECK_EN adds rejection of non-decimal input digits.
module bcd2bin_seq #(
   parameter int MAX_VAL = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] BCD1,
   input  logic [3:0] BCD0,
   output logic [5:0] valoare_bin,
   output logic       eroare,
   output logic       gata,
   output logic       ocupat
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK,
      DONE
   } state_t;

   localparam logic [6:0] MAX_LIM   = 7'(MAX_VAL);
   localparam logic [2:0] LAST_ITER = 3'd6;

   state_t      state;
   logic [7:0]  bcd_q;
   logic [6:0]  acc_q;
   logic [2:0]  iter_q;

   logic [14:0] shifted;
   logic [3:0]  dig_hi;
   logic [3:0]  dig_lo;

   // One reverse double-dabble step: shift the 15-bit pair right, then undo the
   // decimal carry in any digit that picked up a weight-8 bit from its neighbour.
   // NOTE: always_comb uses blocking assignments so later lines see the
   // corrected digits; every variable gets a value first, so no latch is inferred.
   always_comb begin
      shifted = {1'b0, bcd_q, acc_q[6:1]};
      dig_hi  = shifted[14:11];
      dig_lo  = shifted[10:7];
      if (dig_hi >= 4'd8) dig_hi = dig_hi - 4'd3;
      if (dig_lo >= 4'd8) dig_lo = dig_lo - 4'd3;
   end

   // NOTE: sequential state uses non-blocking assignments only, and every
   // register (including the datapath ones) is cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_q       <= '0;
         acc_q       <= '0;
         iter_q      <= '0;
         valoare_bin <= '0;
         eroare      <= 1'b0;
         gata        <= 1'b0;
         ocupat      <= 1'b0;
      end else begin
         gata <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_q  <= {BCD1, BCD0};
                  acc_q  <= '0;
                  iter_q <= '0;
                  ocupat <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  if ((BCD1 > 4'd9) || (BCD0 > 4'd9)) begin
                     valoare_bin <= '0;
                     eroare      <= 1'b1;
                     gata        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
`else
                  state <= SHIFT;
`endif
               end
            end

            SHIFT: begin
               bcd_q <= {dig_hi, dig_lo};
               acc_q <= shifted[6:0];
               if (iter_q == LAST_ITER) begin
                  state <= CHECK;
               end else begin
                  iter_q <= iter_q + 3'd1;
               end
            end

            CHECK: begin
               // Out-of-range results are reported as zero with the error flag set.
               if (acc_q <= MAX_LIM) begin
                  valoare_bin <= acc_q[5:0];
                  eroare      <= 1'b0;
               end else begin
                  valoare_bin <= '0;
                  eroare      <= 1'b1;
               end
               gata  <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               ocupat <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               ocupat <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed conversions, scoreboard of expected
// results, latency/busy checks, back-to-back starts and reset abort.
module tb_bcd2bin_seq;

   typedef struct packed {
      logic [5:0] val;
      logic       err;
   } exp_t;

   localparam int MAX_VAL = 59;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] BCD1 = '0;
   logic [3:0] BCD0 = '0;
   logic [5:0] valoare_bin;
   logic       eroare;
   logic       gata;
   logic       ocupat;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [5:0] prev_val = '0;
   logic       prev_err = 1'b0;

   bcd2bin_seq #(.MAX_VAL(MAX_VAL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .BCD1        (BCD1),
      .BCD0        (BCD0),
      .valoare_bin (valoare_bin),
      .eroare      (eroare),
      .gata        (gata),
      .ocupat      (ocupat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int d1, input int d0);
      exp_t e;
      int   v;
      v = d1 * 10 + d0;
      e.val = (v <= MAX_VAL) ? 6'(v) : 6'd0;
      e.err = (v > MAX_VAL);
      return e;
   endfunction

   task automatic pop_and_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, " scoreboard_nonempty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, " valoare_bin"}, valoare_bin, e.val);
         check({tag, " eroare"}, eroare, e.err);
         prev_val = e.val;
         prev_err = e.err;
      end
   endtask

   // One conversion: drive at a falling edge, wait (bounded) for gata, compare.
   task automatic run_conv(input logic [3:0] d1, input logic [3:0] d0, input int exp_lat,
                           input bit disturb, input string tag);
      int cyc;
      int busy;
      @(negedge clk);
      BCD1  = d1;
      BCD0  = d0;
      start = 1'b1;
      exp_q.push_back(model(d1, d0));
      cyc  = 0;
      busy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (disturb && cyc >= 2 && cyc <= 5) begin
            BCD1  = 4'($urandom_range(0, 9));
            BCD0  = 4'($urandom_range(0, 9));
            start = (cyc < 5);
         end
         if (ocupat) busy++;
         if (!gata && cyc < exp_lat) begin
            check({tag, " hold_val"}, valoare_bin, prev_val);
            check({tag, " hold_err"}, eroare, prev_err);
         end
      end while (!gata && cyc < 30);
      check({tag, " latency"}, cyc, exp_lat);
      check({tag, " busy_cycles"}, busy, exp_lat);
      pop_and_check(tag);
      @(negedge clk);
      check({tag, " gata_pulse_end"}, gata, 0);
      check({tag, " ocupat_end"}, ocupat, 0);
   endtask

   initial begin
      int cyc;
      int inv_lat;
      int gata_seen;

      // Reset state, checked before any clock edge.
      #1;
      check("rst valoare_bin", valoare_bin, 0);
      check("rst eroare", eroare, 0);
      check("rst gata", gata, 0);
      check("rst ocupat", ocupat, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      run_conv(4'd4, 4'd5, 9, 1'b0, "c45");
      run_conv(4'd5, 4'd9, 9, 1'b0, "c59");
      run_conv(4'd6, 4'd0, 9, 1'b0, "c60");
      run_conv(4'd0, 4'd0, 9, 1'b0, "c00");
      run_conv(4'd0, 4'd1, 9, 1'b0, "c01");
      run_conv(4'd9, 4'd9, 9, 1'b0, "c99");
      run_conv(4'd2, 4'd3, 9, 1'b1, "c23_disturbed");
      run_conv(4'd3, 4'd8, 9, 1'b1, "c38_disturbed");

      // Back-to-back with start held high: a result every 10 cycles.
      @(negedge clk);
      BCD1  = 4'd1;
      BCD0  = 4'd2;
      start = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(model(1, 2));
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!gata && cyc < 30);
         check("b2b interval", cyc, (k == 0) ? 9 : 10);
         pop_and_check("b2b");
         if (k == 2) start = 1'b0;
      end
      @(negedge clk);
      check("b2b gata_end", gata, 0);
      repeat (12) @(negedge clk);
      check("b2b no_restart", ocupat, 0);

      // Reset at E4 of a conversion of 37: immediate clear, no gata.
      @(negedge clk);
      BCD1  = 4'd3;
      BCD0  = 4'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort valoare_bin", valoare_bin, 0);
      check("abort eroare", eroare, 0);
      check("abort ocupat", ocupat, 0);
      check("abort gata", gata, 0);
      prev_val = '0;
      prev_err = 1'b0;
      gata_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (gata) gata_seen++;
      end
      check("abort no_gata", gata_seen, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_conv(4'd3, 4'd7, 9, 1'b0, "c37_after_rst");

      // Non-decimal tens digit.
`ifdef BCD2BIN_DIGIT_CHECK_EN
      inv_lat = 1;
`else
      inv_lat = 9;
`endif
      run_conv(4'd10, 4'd3, inv_lat, 1'b0, "c_bad_digit");

      check("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter MAX_VAL, default 59: largest accepted decimal value; legal range 0..63.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to convert; sampled only in IDLE.
REQ-005 BCD1  input  4  tens digit; captured on the accepting edge.
REQ-006 BCD0  input  4  units digit; captured on the accepting edge.
REQ-007 valoare_bin  output  6  binary result, registered, held until the next result.
REQ-008 eroare  output  1  error flag for the last result, registered, held with valoare_bin.
REQ-009 gata  output  1  one-cycle pulse: valoare_bin/eroare just updated.
REQ-010 ocupat  output  1  high whenever state is not IDLE.

Function
REQ-011 States SHALL be IDLE, SHIFT, CHECK, DONE; there are no other reachable states.
REQ-012 IDLE with start=1 on edge E0: capture {BCD1,BCD0} into an 8-bit BCD register, clear a 7-bit binary accumulator, clear the iteration counter, go to SHIFT.
REQ-013 SHIFT: each edge right-shifts {BCD register, accumulator} by 1 as a 15-bit concatenation; then any BCD digit >= 8 has 3 subtracted (reverse double-dabble).
REQ-014 SHIFT SHALL perform exactly 7 iterations (E1..E7); after E7 the state is CHECK.
REQ-015 CHECK (E8): if accumulator <= MAX_VAL, register valoare_bin = accumulator[5:0] and eroare = 0; otherwise register valoare_bin = 0 and eroare = 1. Go to DONE.
REQ-016 DONE: gata = 1 for exactly one cycle; the next edge returns to IDLE. Fixed latency: gata is high in the cycle after E8.
REQ-017 start SHALL be ignored in SHIFT, CHECK and DONE, including start held high from the previous request; a start asserted during DONE is accepted only if it is still high in IDLE.
REQ-018 Back-to-back: with start held high, a new conversion is accepted every 10 cycles.
REQ-019 BCD1/BCD0 changes after E0 SHALL NOT affect the conversion in flight.
REQ-020 valoare_bin and eroare SHALL change only on the CHECK edge or on reset.

Reset
REQ-021 When rst_n = 0, the block SHALL go immediately to IDLE with valoare_bin = 0, eroare = 0, gata = 0, ocupat = 0, internal registers = 0, independent of clk.
REQ-022 Reset during SHIFT, CHECK or DONE SHALL abort the conversion; no gata pulse is produced for it.
REQ-023 The first start is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro BCD2BIN_DIGIT_CHECK_EN compiles in input digit validation.
REQ-025 With the macro defined, if BCD1 > 9 or BCD0 > 9 at E0, the block SHALL skip SHIFT and CHECK. Next state is DONE, with valoare_bin = 0 and eroare = 1 registered on E0, and gata high in the cycle after E0.
REQ-026 Without the macro, digits are not checked; every request runs REQ-013..016 and only the MAX_VAL range check sets eroare.

Verification
REQ-027 Reset, then BCD1=4, BCD0=5, start pulse -> ocupat high for 9 cycles; gata in the cycle after E8; valoare_bin = 6'b101101 (45), eroare = 0.
REQ-028 BCD1=5, BCD0=9 -> valoare_bin = 59 (6'b111011), eroare = 0; BCD1=6, BCD0=0 -> valoare_bin = 0, eroare = 1.
REQ-029 BCD1=0, BCD0=0, then BCD1=0, BCD0=1 -> results 0 and 1. Change BCD inputs mid-SHIFT -> result unchanged. Extra start pulses during SHIFT -> ignored.
REQ-030 start held high continuously with inputs 1,2 -> gata every 10 cycles, valoare_bin = 12 each time.
REQ-031 Assert rst_n = 0 at E4 of a conversion of 37 -> outputs 0 immediately, no gata. After release, convert 37 -> valoare_bin = 37.
REQ-032 BCD1=10, BCD0=3: with BCD2BIN_DIGIT_CHECK_EN -> gata in the cycle after E0, eroare = 1, valoare_bin = 0. Without the macro -> gata after E8, and eroare is set only if the result exceeds 59.
